// File: rtl/bcd_display_sequencer.sv
// -----------------------------------------------------------------------------
// bcd_display_sequencer
//
// Converts a 32-bit two's-complement operand into sign + BCD digits with the
// shift-and-add-3 (double dabble) algorithm, one magnitude bit per clock, and
// drives an 8-position multiplexed seven-segment display from the committed
// result. Position 7 carries the sign; positions 0..6 carry d0..d6.
//
// Optional feature macro: BCD_LZB_EN
//   defined   -> leading-zero blanking on positions 1..6
//   undefined -> every digit position always shows its digit
//
// Parameters:
//   SCAN_DIV  clocks each display position stays enabled (>= 2)
//
// Ports:
//   clk       in   system clock, rising-edge
//   reset     in   synchronous active-high reset
//   start     in   request a conversion (honoured only while ready = 1)
//   value     in   32-bit two's-complement operand, sampled on the accept edge
//   ready     out  high while idle
//   done      out  one-cycle pulse when d0..d6/negative/ovf were just updated
//   negative  out  committed sign of the last operand
//   ovf       out  committed |value| > 9,999,999
//   d0..d6    out  committed BCD digits, d0 least significant
//   an        out  active-low one-hot position enable (bit 7 = sign)
//   seg       out  active-low segments, order gfedcba
// -----------------------------------------------------------------------------
module bcd_display_sequencer #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] value,
    output logic        ready,
    output logic        done,
    output logic        negative,
    output logic        ovf,
    output logic [3:0]  d0,
    output logic [3:0]  d1,
    output logic [3:0]  d2,
    output logic [3:0]  d3,
    output logic [3:0]  d4,
    output logic [3:0]  d5,
    output logic [3:0]  d6,
    output logic [7:0]  an,
    output logic [6:0]  seg
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Conversion datapath state
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [31:0] r_mag;
    logic [39:0] r_bcd;
    logic [4:0]  r_cnt;
    logic        r_sign;

    // Committed, externally visible results
    logic        r_ready;
    logic        r_done;
    logic        r_neg;
    logic        r_ovf;
    logic [27:0] r_digits;      // {d6, d5, ..., d0}

    // Add-3 correction applied to every nibble before the shift
    logic [39:0] w_bcd_adj;
    logic [39:0] w_bcd_shift;

    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_add3
            assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5)
                                        ? (r_bcd[gi*4 +: 4] + 4'd3)
                                        : r_bcd[gi*4 +: 4];
        end
    endgenerate

    assign w_bcd_shift = {w_bcd_adj[38:0], r_mag[31]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_mag    <= 32'd0;
            r_bcd    <= 40'd0;
            r_cnt    <= 5'd0;
            r_sign   <= 1'b0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_neg    <= 1'b0;
            r_ovf    <= 1'b0;
            r_digits <= 28'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        // 0x80000000 negates to itself, which is the correct
                        // unsigned magnitude 2147483648.
                        r_mag   <= value[31] ? (~value + 32'd1) : value;
                        r_sign  <= value[31];
                        r_bcd   <= 40'd0;
                        r_cnt   <= 5'd31;
                        r_ready <= 1'b0;
                        r_state <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    r_bcd <= w_bcd_shift;
                    r_mag <= {r_mag[30:0], 1'b0};
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd0) begin
                        // Commit from the final shifted value so the result
                        // appears on the same edge as the last shift.
                        r_digits <= w_bcd_shift[27:0];
                        r_ovf    <= |w_bcd_shift[39:28];
                        r_neg    <= r_sign;
                        r_done   <= 1'b1;
                        r_ready  <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Display scan: free-running divider and position counter
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_pos;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= '0;
            r_pos <= 3'd0;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
            r_pos <= r_pos + 3'd1;   // wraps 7 -> 0
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Top nibble padded so the position index never leaves the vector
    logic [31:0] w_dig_flat;
    logic [3:0]  w_dig_sel;
    logic        w_blank;

    assign w_dig_flat = {4'h0, r_digits};
    assign w_dig_sel  = w_dig_flat[{r_pos, 2'b00} +: 4];

`ifdef BCD_LZB_EN
    // w_lead_zero[p] = digit p and every higher digit are zero.
    logic [7:0] w_lead_zero;

    assign w_lead_zero[7] = 1'b1;
    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_lzb
            assign w_lead_zero[gi] = ~|r_digits[27:gi*4];
        end
    endgenerate

    assign w_blank = (r_pos != 3'd0) && w_lead_zero[r_pos];
`else
    assign w_blank = 1'b0;
`endif

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_decode = 7'h40;
            4'd1:    seg_decode = 7'h79;
            4'd2:    seg_decode = 7'h24;
            4'd3:    seg_decode = 7'h30;
            4'd4:    seg_decode = 7'h19;
            4'd5:    seg_decode = 7'h12;
            4'd6:    seg_decode = 7'h02;
            4'd7:    seg_decode = 7'h78;
            4'd8:    seg_decode = 7'h00;
            4'd9:    seg_decode = 7'h10;
            default: seg_decode = 7'h7F;
        endcase
    endfunction

    always_comb begin
        seg = 7'h7F;
        if (r_pos == 3'd7) begin
            seg = r_neg ? 7'b0111111 : 7'h7F;
        end else if (!w_blank) begin
            seg = seg_decode(w_dig_sel);
        end
    end

    assign an = ~(8'b0000_0001 << r_pos);

    assign ready    = r_ready;
    assign done     = r_done;
    assign negative = r_neg;
    assign ovf      = r_ovf;
    assign d0       = r_digits[3:0];
    assign d1       = r_digits[7:4];
    assign d2       = r_digits[11:8];
    assign d3       = r_digits[15:12];
    assign d4       = r_digits[19:16];
    assign d5       = r_digits[23:20];
    assign d6       = r_digits[27:24];

endmodule

// File: tb/tb_bcd_display_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for bcd_display_sequencer (SCAN_DIV = 4).
// Table of operands with hand-computed BCD results, followed by directed
// sequences for start-while-busy, back-to-back start, mid-conversion reset,
// sign display and the position scan.
// -----------------------------------------------------------------------------
module tb_bcd_display_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] value;
    logic        ready;
    logic        done;
    logic        negative;
    logic        ovf;
    logic [3:0]  d0, d1, d2, d3, d4, d5, d6;
    logic [7:0]  an;
    logic [6:0]  seg;

    int checks;
    int errors;

    bcd_display_sequencer #(.SCAN_DIV(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .value    (value),
        .ready    (ready),
        .done     (done),
        .negative (negative),
        .ovf      (ovf),
        .d0       (d0),
        .d1       (d1),
        .d2       (d2),
        .d3       (d3),
        .d4       (d4),
        .d5       (d5),
        .d6       (d6),
        .an       (an),
        .seg      (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] val;
        logic [27:0] digits;   // {d6..d0}, BCD reads like hex
        logic        neg;
        logic        ovf;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [27:0] digits_now();
        return {d6, d5, d4, d3, d2, d1, d0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a conversion and returns the clocks from the accept edge to the
    // first cycle where done is high (-1 on timeout).
    task automatic run_conv(input logic [31:0] v, output int lat);
        int n;
        n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        start = 1'b1;
        value = v;
        lat = -1;
        n = 0;
        while (n < 100) begin
            tick();
            start = 1'b0;
            n++;
            if (n == 1) check("ready_low_busy", {31'd0, ready}, 32'd0);
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic wait_an(input logic [7:0] target);
        int n;
        n = 0;
        while (an !== target && n < 200) begin
            tick();
            n++;
        end
        check("wait_an", {24'd0, an}, {24'd0, target});
    endtask

    int lat;
    int dones;
    logic [6:0] exp_seg[8];

    initial begin
        checks = 0;
        errors = 0;
        start  = 1'b0;
        value  = 32'd0;
        reset  = 1'b1;

        vecs[0] = '{32'd1234567,   28'h1234567, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFFF,  28'h0000001, 1'b1, 1'b0};
        vecs[2] = '{32'h80000000,  28'h7483648, 1'b1, 1'b1};
        vecs[3] = '{32'd9999999,   28'h9999999, 1'b0, 1'b0};
        vecs[4] = '{32'd10000000,  28'h0000000, 1'b0, 1'b1};
        vecs[5] = '{32'hFF676981,  28'h9999999, 1'b1, 1'b0};  // -9999999
        vecs[6] = '{32'd0,         28'h0000000, 1'b0, 1'b0};
        vecs[7] = '{32'd7654321,   28'h7654321, 1'b0, 1'b0};

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_ready", {31'd0, ready},    32'd1);
        check("rst_done",  {31'd0, done},     32'd0);
        check("rst_neg",   {31'd0, negative}, 32'd0);
        check("rst_ovf",   {31'd0, ovf},      32'd0);
        check("rst_digits", {4'd0, digits_now()}, 32'd0);
        check("rst_an",    {24'd0, an},  32'h0000_00FE);
        check("rst_seg",   {25'd0, seg}, 32'h0000_0040);
        reset = 1'b0;
        tick();

        // ---------------- table-driven conversions ----------------
        for (int i = 0; i < 8; i++) begin
            run_conv(vecs[i].val, lat);
            $display("conv value=%h latency=%0d digits=%h neg=%0b ovf=%0b",
                     vecs[i].val, lat, digits_now(), negative, ovf);
            check("latency", lat, 32'd33);
            check("digits",  {4'd0, digits_now()}, {4'd0, vecs[i].digits});
            check("negative", {31'd0, negative}, {31'd0, vecs[i].neg});
            check("ovf",      {31'd0, ovf},      {31'd0, vecs[i].ovf});
            check("ready_done_cycle", {31'd0, ready}, 32'd1);
            tick();
            check("done_pulse_one", {31'd0, done}, 32'd0);
        end

        // ---------------- sign on position 7 ----------------
        run_conv(32'hFFFFFFFF, lat);
        wait_an(8'h7F);
        check("sign_seg", {25'd0, seg}, {25'd0, 7'b0111111});
        $display("sign position an=%h seg=%h", an, seg);

        // ---------------- start while busy ignored ----------------
        start = 1'b1;
        value = 32'd100;
        tick();                       // accept edge
        start = 1'b0;
        lat = -1;
        dones = 0;
        for (int n = 1; n < 100; n++) begin
            if (n == 10) begin
                start = 1'b1;
                value = 32'd555;
            end
            tick();
            start = 1'b0;
            if (done) begin
                dones++;
                lat = n + 1;
                break;
            end
        end
        $display("busy start: latency=%0d digits=%h", lat, digits_now());
        check("busy_latency", lat, 32'd33);
        check("busy_digits", {4'd0, digits_now()}, 32'h0000100);

        // start held in the done cycle -> accepted back-to-back
        start = 1'b1;
        value = 32'd555;
        lat = -1;
        for (int n = 1; n < 100; n++) begin
            tick();
            start = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
        end
        $display("back-to-back: latency=%0d digits=%h", lat, digits_now());
        check("b2b_latency", lat, 32'd33);
        check("b2b_digits", {4'd0, digits_now()}, 32'h0000555);
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (done) dones++;
        end
        check("no_extra_done", dones, 32'd0);

        // ---------------- reset mid-conversion ----------------
        start = 1'b1;
        value = 32'd1234567;
        tick();                       // accept edge
        start = 1'b0;
        for (int n = 0; n < 16; n++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_ready",  {31'd0, ready},    32'd1);
        check("abort_done",   {31'd0, done},     32'd0);
        check("abort_digits", {4'd0, digits_now()}, 32'd0);
        check("abort_neg",    {31'd0, negative}, 32'd0);
        check("abort_ovf",    {31'd0, ovf},      32'd0);
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (done) dones++;
        end
        check("abort_no_done", dones, 32'd0);
        $display("abort: ready=%0b digits=%h dones=%0d", ready, digits_now(), dones);

        run_conv(32'd42, lat);
        check("post_abort_latency", lat, 32'd33);
        check("post_abort_digits", {4'd0, digits_now()}, 32'h0000042);

        // ---------------- scan of value 42 ----------------
        exp_seg[0] = 7'h24;
        exp_seg[1] = 7'h19;
`ifdef BCD_LZB_EN
        for (int p = 2; p < 7; p++) exp_seg[p] = 7'h7F;
`else
        for (int p = 2; p < 7; p++) exp_seg[p] = 7'h40;
`endif
        exp_seg[7] = 7'h7F;

        wait_an(8'h7F);
        wait_an(8'hFE);
        for (int p = 0; p < 8; p++) begin
            $display("scan pos=%0d an=%h seg=%h", p, an, seg);
            for (int c = 0; c < 4; c++) begin
                check("scan_an",  {24'd0, an},  {24'd0, ~(8'd1 << p)});
                check("scan_seg", {25'd0, seg}, {25'd0, exp_seg[p]});
                tick();
            end
        end
        check("scan_wrap", {24'd0, an}, 32'h0000_00FE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
